// File: rtl/c432_lock_pkg.sv
// Shared widths, key bit positions and FSM state encodings for the c432 key-locked core wrapper.
package c432_lock_pkg;
    localparam int KEY_W   = 27;
    localparam int IN_W    = 36;
    localparam int OUT_W   = 7;
    localparam int FRAME_W = KEY_W + 1;  // key bits followed by one parity bit
    localparam int P1_IDX  = 0;
    localparam int X1_IDX  = 4;

    typedef enum logic [1:0] {
        K_IDLE,
        K_SHIFT,
        K_CHECK
    } key_state_t;

    typedef enum logic [1:0] {
        E_IDLE,
        E_SETTLE,
        E_RESP
    } eval_state_t;

    // True when the frame holds an even number of ones.
    function automatic logic frame_parity_ok(input logic [FRAME_W-1:0] frame);
        return ~(^frame);
    endfunction
endpackage

// File: rtl/c432_key_rx.sv
// Serial key receiver: shifts in a 27-bit key plus parity, then commits it or flags an error.
module c432_key_rx
    import c432_lock_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             key_start,
    input  logic             key_bit_valid,
    input  logic             key_bit,
    input  logic             i_eval_idle,
    output logic             key_bit_ready,
    output logic             key_ok,
    output logic             key_err,
    output logic [KEY_W-1:0] core_key
);
    key_state_t         r_state;
    key_state_t         w_next;
    logic [FRAME_W-1:0] r_shadow;
    logic [4:0]         r_cnt;
    logic               w_start;
    logic               w_xfer;
    logic               w_last;

    // A new frame may only begin while no evaluation is using the committed key.
    assign w_start       = key_start & i_eval_idle & (r_state != K_CHECK);
    assign w_xfer        = key_bit_valid & (r_state == K_SHIFT) & ~w_start;
    assign w_last        = w_xfer & (r_cnt == 5'(FRAME_W - 1));
    assign key_bit_ready = (r_state == K_SHIFT);

    always_comb begin
        // NOTE: next state defaults to the current state so no path leaves it unassigned (no latch).
        w_next = r_state;
        case (r_state)
            K_IDLE:  if (w_start) w_next = K_SHIFT;
            K_SHIFT: begin
                if (w_start)     w_next = K_SHIFT;
                else if (w_last) w_next = K_CHECK;
            end
            K_CHECK: w_next = K_IDLE;
            default: w_next = K_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= K_IDLE;
        else        r_state <= w_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shadow <= '0;
            r_cnt    <= '0;
            key_ok   <= 1'b0;
            key_err  <= 1'b0;
            core_key <= '0;
        end else begin
            if (w_start) begin
                r_cnt   <= '0;
                key_ok  <= 1'b0;
                key_err <= 1'b0;
            end else if (w_xfer) begin
                r_shadow <= {r_shadow[FRAME_W-2:0], key_bit};
                r_cnt    <= r_cnt + 5'd1;
            end
            if (r_state == K_CHECK) begin
                if (frame_parity_ok(r_shadow)) begin
                    core_key <= r_shadow[FRAME_W-1:1];
                    key_ok   <= 1'b1;
                end else begin
                    core_key <= '0;
                    key_err  <= 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/c432_lock_ctrl.sv
// Top: key receiver plus a single-shot evaluation sequencer that drives the locked core and samples it.
module c432_lock_ctrl
    import c432_lock_pkg::*;
#(
    parameter int SETTLE = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             key_start,
    input  logic             key_bit_valid,
    input  logic             key_bit,
    output logic             key_bit_ready,
    output logic             key_ok,
    output logic             key_err,
    output logic [KEY_W-1:0] core_key,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [IN_W-1:0]  req_vec,
    output logic [IN_W-1:0]  core_in,
    input  logic [OUT_W-1:0] core_out,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [OUT_W-1:0] rsp_vec
);
    eval_state_t r_state;
    eval_state_t w_next;
    logic [3:0]  r_cnt;
    logic        w_req_xfer;

    c432_key_rx u_key_rx (
        .clk           (clk),
        .rst_n         (rst_n),
        .key_start     (key_start),
        .key_bit_valid (key_bit_valid),
        .key_bit       (key_bit),
        .i_eval_idle   (r_state == E_IDLE),
        .key_bit_ready (key_bit_ready),
        .key_ok        (key_ok),
        .key_err       (key_err),
        .core_key      (core_key)
    );

    assign req_ready  = key_ok & (r_state == E_IDLE);
    assign w_req_xfer = req_valid & req_ready;
    assign rsp_valid  = (r_state == E_RESP);

    always_comb begin
        w_next = r_state;
        case (r_state)
            E_IDLE:   if (w_req_xfer)    w_next = E_SETTLE;
            E_SETTLE: if (r_cnt == 4'd0) w_next = E_RESP;
            E_RESP:   if (rsp_ready)     w_next = E_IDLE;
            default:  w_next = E_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= E_IDLE;
        else        r_state <= w_next;
    end

    // core_in and rsp_vec are only loaded at their events and otherwise hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            core_in <= '0;
            rsp_vec <= '0;
        end else begin
            if (w_req_xfer) begin
                core_in <= req_vec;
                r_cnt   <= 4'(SETTLE - 1);
            end else if (r_state == E_SETTLE) begin
                if (r_cnt == 4'd0) rsp_vec <= core_out;
                else               r_cnt   <= r_cnt - 4'd1;
            end
        end
    end
endmodule

// File: tb/tb_c432_lock_ctrl.sv
// Directed bench: table-driven key frames and evaluations plus hand-written reset/interlock sequences.
module tb_c432_lock_ctrl;
    import c432_lock_pkg::*;

    localparam int SETTLE = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             key_start = 1'b0;
    logic             key_bit_valid = 1'b0;
    logic             key_bit = 1'b0;
    logic             key_bit_ready;
    logic             key_ok;
    logic             key_err;
    logic [KEY_W-1:0] core_key;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic [IN_W-1:0]  req_vec = '0;
    logic [IN_W-1:0]  core_in;
    logic [OUT_W-1:0] core_out;
    logic             rsp_valid;
    logic             rsp_ready = 1'b0;
    logic [OUT_W-1:0] rsp_vec;
    logic             fixed_en = 1'b1;

    int n_checks = 0;
    int n_errors = 0;

    // Core model: either a fixed pattern or a simple function of the driven inputs.
    assign core_out = fixed_en ? 7'h55 : (core_in[6:0] ^ 7'h2A);

    always #5 clk = ~clk;

    c432_lock_ctrl #(.SETTLE(SETTLE)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .key_start     (key_start),
        .key_bit_valid (key_bit_valid),
        .key_bit       (key_bit),
        .key_bit_ready (key_bit_ready),
        .key_ok        (key_ok),
        .key_err       (key_err),
        .core_key      (core_key),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_vec       (req_vec),
        .core_in       (core_in),
        .core_out      (core_out),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_vec       (rsp_vec)
    );

    typedef struct {
        logic [KEY_W-1:0] key;
        logic             par;
        logic             exp_ok;
        logic             exp_err;
        logic [KEY_W-1:0] exp_key;
    } key_vec_t;

    typedef struct {
        logic [IN_W-1:0]  vec;
        logic             fixed;
        logic [OUT_W-1:0] exp_rsp;
        int               hold;
    } eval_vec_t;

    key_vec_t  key_tbl [5];
    eval_vec_t eval_tbl[4];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic start_frame();
        key_start = 1'b1;
        @(negedge clk);
        key_start = 1'b0;
    endtask

    task automatic send_bits(input logic [KEY_W-1:0] key, input logic par, input int nbits);
        logic [FRAME_W-1:0] frame;
        frame = {key, par};
        for (int i = 0; i < nbits; i++) begin
            key_bit_valid = 1'b1;
            key_bit       = frame[FRAME_W-1-i];
            @(negedge clk);
        end
        key_bit_valid = 1'b0;
        key_bit       = 1'b0;
    endtask

    // Sends a full frame and leaves the bench one cycle after the commit edge.
    task automatic send_frame(input logic [KEY_W-1:0] key, input logic par);
        start_frame();
        check("bit_ready_after_start", key_bit_ready, 1'b1);
        send_bits(key, par, FRAME_W);
        check("no_early_commit", {key_ok, key_err}, 2'b00);
        @(negedge clk);
    endtask

    task automatic do_eval(input logic [IN_W-1:0] vec, input logic [OUT_W-1:0] exp_rsp,
                           input int hold);
        check("req_ready_idle", req_ready, 1'b1);
        req_valid = 1'b1;
        req_vec   = vec;
        @(negedge clk);
        req_valid = 1'b0;
        check("core_in_driven", core_in, vec);
        check("req_ready_busy", req_ready, 1'b0);
        for (int i = 1; i < SETTLE; i++) begin
            check("rsp_valid_early", rsp_valid, 1'b0);
            @(negedge clk);
        end
        @(negedge clk);
        check("rsp_valid_latency", rsp_valid, 1'b1);
        check("rsp_vec", rsp_vec, exp_rsp);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("rsp_hold_valid", rsp_valid, 1'b1);
            check("rsp_hold_vec", rsp_vec, exp_rsp);
            check("rsp_hold_req_ready", req_ready, 1'b0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("rsp_done", rsp_valid, 1'b0);
        check("req_ready_after_rsp", req_ready, 1'b1);
        check("core_in_holds", core_in, vec);
    endtask

    initial begin
        key_tbl[0] = '{27'h0000001, 1'b1, 1'b1, 1'b0, 27'h0000001};
        key_tbl[1] = '{27'h7FFFFFF, 1'b0, 1'b0, 1'b1, 27'h0000000};
        key_tbl[2] = '{27'h5A5A5A5, 1'b0, 1'b1, 1'b0, 27'h5A5A5A5};
        key_tbl[3] = '{27'h5A5A5A5, 1'b1, 1'b0, 1'b1, 27'h0000000};
        key_tbl[4] = '{27'h1234567, 1'b0, 1'b1, 1'b0, 27'h1234567};

        eval_tbl[0] = '{36'h0F0F0F0F0, 1'b1, 7'h55, 5};
        eval_tbl[1] = '{36'h0F0F0F0F0, 1'b0, 7'h5A, 0};
        eval_tbl[2] = '{36'hFFFFFFFFF, 1'b0, 7'h55, 1};
        eval_tbl[3] = '{36'h000000013, 1'b0, 7'h39, 0};

        #1;
        check("rst_outputs",
              {key_bit_ready, key_ok, key_err, core_key, req_ready, rsp_valid, rsp_vec},
              '0);
        check("rst_core_in", core_in, '0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            send_frame(key_tbl[i].key, key_tbl[i].par);
            check("key_ok", key_ok, key_tbl[i].exp_ok);
            check("key_err", key_err, key_tbl[i].exp_err);
            check("core_key", core_key, key_tbl[i].exp_key);
            check("req_ready_key", req_ready, key_tbl[i].exp_ok);
            check("bit_ready_idle", key_bit_ready, 1'b0);
        end

        for (int i = 0; i < 4; i++) begin
            fixed_en = eval_tbl[i].fixed;
            do_eval(eval_tbl[i].vec, eval_tbl[i].exp_rsp, eval_tbl[i].hold);
        end

        // key_start while an evaluation is in flight must not disturb the key.
        fixed_en  = 1'b0;
        req_valid = 1'b1;
        req_vec   = 36'h000000013;
        @(negedge clk);
        req_valid = 1'b0;
        key_start = 1'b1;
        @(negedge clk);
        key_start = 1'b0;
        check("start_in_settle_ok", key_ok, 1'b1);
        check("start_in_settle_rdy", key_bit_ready, 1'b0);
        @(negedge clk);
        check("settle_rsp_valid", rsp_valid, 1'b1);
        check("settle_rsp_vec", rsp_vec, 7'h39);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        start_frame();
        check("start_after_rsp_ok", key_ok, 1'b0);
        check("start_after_rsp_rdy", key_bit_ready, 1'b1);
        check("key_held_in_frame", core_key, 27'h1234567);
        check("req_blocked_in_frame", req_ready, 1'b0);
        send_bits(27'h0000001, 1'b1, FRAME_W);
        @(negedge clk);
        check("recommit_ok", key_ok, 1'b1);
        check("recommit_key", core_key, 27'h0000001);

        // Start plus bit in the same cycle: the bit is dropped and the frame realigns.
        key_start     = 1'b1;
        key_bit_valid = 1'b1;
        key_bit       = 1'b1;
        @(negedge clk);
        key_start = 1'b0;
        send_bits(27'h5A5A5A5, 1'b0, FRAME_W);
        @(negedge clk);
        check("start_wins_ok", key_ok, 1'b1);
        check("start_wins_key", core_key, 27'h5A5A5A5);

        // Asynchronous reset mid-frame after an evaluation left core_in/rsp_vec non-zero.
        fixed_en = 1'b1;
        do_eval(36'h0F0F0F0F0, 7'h55, 0);
        start_frame();
        send_bits(27'h7FFFFFF, 1'b1, 10);
        #2 rst_n = 1'b0;
        #1;
        check("midframe_rst_outputs",
              {key_bit_ready, key_ok, key_err, core_key, req_ready, rsp_valid, rsp_vec},
              '0);
        check("midframe_rst_core_in", core_in, '0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_frame(27'h0000001, 1'b1);
        check("post_rst_ok", key_ok, 1'b1);
        check("post_rst_key", core_key, 27'h0000001);
        check("post_rst_req_ready", req_ready, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
